// File: rtl/uart_rx.sv
// UART receive front-end: 2-flop synchroniser, internal oversampling tick, 8N1 framing with
// a valid/ready output. Define UART_RX_PARITY_EN to add an even-parity bit (8E1 framing).
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] word,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e         state_q, state_d;
  logic           rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [DW-1:0]  div_q, div_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d, word_q, word_d;
  logic           valid_q, valid_d, busy_q, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic           tick, mid_start, bit_end;
`ifdef UART_RX_PARITY_EN
  logic           par_err_q, par_err_d;
`endif

  assign tick      = (div_q == DW'(TICK_DIV - 1));
  assign mid_start = tick && (tcnt_q == TW'(OVERSAMPLE / 2 - 1));
  assign bit_end   = tick && (tcnt_q == TW'(OVERSAMPLE - 1));

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    tcnt_d      = tick ? tcnt_q + 1'b1 : tcnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    word_d      = word_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    // Accept is applied first so a same-cycle load below can refill the slot.
    if (valid_q && ready) begin
      valid_d = 1'b0;
      word_d  = data_q;
    end
    unique case (state_q)
      StIdle: begin
        if (rxd_prev_q && !rxd_s_q) begin
          tcnt_d  = '0;
          div_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (mid_start) begin
          if (!rxd_s_q) begin
            tcnt_d    = '0;
            bit_idx_d = '0;
            state_d   = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (bit_end) begin
          par_err_d = ^{shift_q, rxd_s_q};
          state_d   = StStop;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (bit_end) begin
`ifdef UART_RX_PARITY_EN
          if (par_err_q) begin
            frame_err_d = 1'b1;
            state_d     = rxd_s_q ? StIdle : StBreak;
          end else
`endif
          if (rxd_s_q) begin
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        if (rxd_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_prev_q  <= 1'b1;
      div_q       <= '0;
      tcnt_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      rxd_prev_q  <= rxd_s_q;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      word_q      <= word_d;
      busy_q      <= (state_d != StIdle);
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign word      = word_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written glitch, framing,
// back-pressure, reset and (when UART_RX_PARITY_EN is defined) parity sequences.
module tb_uart_rx;

  localparam int BIT = 160;  // clocks per bit at 1.6 MHz / 10 kBd
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data, word;
  logic       valid, busy, frame_err, overrun;

  uart_rx #(
    .CLK_FREQ  (1600000),
    .BAUD      (10000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .word     (word),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Event counters; tests compare deltas across a sequence.
  int         acc_cnt = 0, ferr_cnt = 0, vhi_cnt = 0, brise_cnt = 0;
  logic [7:0] last_acc = 8'h00;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    busy_prev <= busy;
    if (busy && !busy_prev) brise_cnt <= brise_cnt + 1;
    if (valid) vhi_cnt <= vhi_cnt + 1;
    if (valid && ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= data;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Frame with given stop level held for stop_bits periods, then two idle bit times.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_v,
                            input int stop_bits);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    if (PAR_EN) hold(par, BIT);
    hold(stop_v, stop_bits * BIT);
    hold(1'b1, 2 * BIT);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_v;
    int         exp_acc;
    int         exp_ferr;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[6];
  int   a0, f0, v0, b0;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'hA3, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_word", 32'(word), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    hold(1'b1, BIT);

    // Table of single frames with ready held high
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a0 = acc_cnt; f0 = ferr_cnt; v0 = vhi_cnt;
      send_frame(vecs[i].b, ^vecs[i].b, vecs[i].stop_v, 1);
      chk($sformatf("vec%0d_accepts", i), acc_cnt - a0, vecs[i].exp_acc);
      chk($sformatf("vec%0d_valid_clks", i), vhi_cnt - v0, vecs[i].exp_acc);
      chk($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_word", i), 32'(word), 32'(vecs[i].exp_word));
      if (vecs[i].exp_acc == 1) chk($sformatf("vec%0d_data", i), 32'(last_acc), 32'(vecs[i].b));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 0);
      chk($sformatf("vec%0d_busy_idle", i), 32'(busy), 0);
    end

    // Start glitch shorter than half a bit
    a0 = acc_cnt; f0 = ferr_cnt; b0 = brise_cnt;
    hold(1'b0, 30);
    hold(1'b1, 2 * BIT);
    chk("glitch_busy_rise", brise_cnt - b0, 1);
    chk("glitch_busy_idle", 32'(busy), 0);
    chk("glitch_accepts", acc_cnt - a0, 0);
    chk("glitch_frame_err", ferr_cnt - f0, 0);

    // Framing error with the line held low for three bit times, then a clean frame
    a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, ^8'hA3, 1'b0, 3);
    chk("brk_frame_err", ferr_cnt - f0, 1);
    chk("brk_accepts", acc_cnt - a0, 0);
    chk("brk_busy_idle", 32'(busy), 0);
    a0 = acc_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b1, 1);
    chk("after_brk_accepts", acc_cnt - a0, 1);
    chk("after_brk_word", 32'(word), 32'h3C);

    // Back-pressure: second byte is dropped and overrun sticks
    ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1, 1);
    chk("bp1_valid", 32'(valid), 1);
    chk("bp1_data", 32'(data), 32'h11);
    chk("bp1_overrun", 32'(overrun), 0);
    send_frame(8'h22, ^8'h22, 1'b1, 1);
    chk("bp2_data", 32'(data), 32'h11);
    chk("bp2_overrun", 32'(overrun), 1);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_word", 32'(word), 32'h11);
    chk("bp_valid_clr", 32'(valid), 0);
    chk("bp_overrun_sticky", 32'(overrun), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_overrun_rst", 32'(overrun), 0);
    rst = 1'b0;
    hold(1'b1, BIT);

    // Reset during data bit 4 of 0xFF, then a clean 0x80
    a0 = acc_cnt; f0 = ferr_cnt;
    hold(1'b0, BIT);
    hold(1'b1, 4 * BIT + BIT / 2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_data", 32'(data), 0);
    chk("midrst_word", 32'(word), 0);
    chk("midrst_frame_err", 32'(frame_err), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    hold(1'b1, 4 * BIT);
    send_frame(8'h80, ^8'h80, 1'b1, 1);
    chk("midrst_accepts", acc_cnt - a0, 1);
    chk("midrst_last", 32'(last_acc), 32'h80);
    chk("midrst_word80", 32'(word), 32'h80);
    chk("midrst_ferr", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has odd weight, so the parity bit must be 1
    a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1);
    chk("par_ok_accepts", acc_cnt - a0, 1);
    chk("par_ok_data", 32'(last_acc), 32'h07);
    chk("par_ok_ferr", ferr_cnt - f0, 0);
    a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'h07, 1'b0, 1'b1, 1);
    chk("par_bad_accepts", acc_cnt - a0, 0);
    chk("par_bad_ferr", ferr_cnt - f0, 1);
    chk("par_bad_busy", 32'(busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
